mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Shares one WIDTH-bit 2:1 datapath mux between two streaming requesters (in0, in1) using valid/ready handshakes.
- Round-robin grant with burst locking: the grant is held until the requester sends a beat with last=1, or until MAX_BURST beats have been accepted.
- The mux select is driven from the grant state. The output is registered, one beat deep.
- Sits between two producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8, data width of each input and of the output.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in0_valid  input  1  requester 0 has a beat.
- in0_data  input  WIDTH  requester 0 beat data.
- in0_last  input  1  requester 0 beat ends its burst.
- in0_ready  output  1  requester 0 beat accepted this cycle when in0_valid is also high.
- in1_valid  input  1  requester 1 has a beat.
- in1_data  input  WIDTH  requester 1 beat data.
- in1_last  input  1  requester 1 beat ends its burst.
- in1_ready  output  1  requester 1 beat accepted this cycle when in1_valid is also high.
- out_valid  output  1  registered output beat is valid.
- out_data  output  WIDTH  registered output data.
- out_last  output  1  burst end; high on the closing beat (last=1 or the MAX_BURST-th beat).
- out_src  output  1  source of the current output beat (0 = in0, 1 = in1).
- out_ready  input  1  consumer accepts the output beat.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n=0 immediately forces:
  - state=IDLE, out_valid=0, out_data=0, out_last=0, out_src=0;
  - beat counter=0, priority pointer=0 (in0 preferred);
  - in0_ready=0, in1_ready=0.
- Reset mid-burst: any beat in flight is dropped. After release, arbitration restarts from IDLE with in0 preferred.
- States:
  - IDLE: no grant. Both readys are 0.
  - GRANT0: in0 owns the mux.
  - GRANT1: in1 owns the mux.
- IDLE transitions (evaluated each cycle):
  - Only one valid: grant that requester.
  - Both valid: grant the requester indicated by the pointer.
  - Neither valid: stay in IDLE.
  - The transition takes effect next cycle, so there is a one-cycle arbitration bubble per grant.
- Output register advance: adv = !out_valid || out_ready.
- Ready generation (combinational from state and the output register):
  - in0_ready = (state==GRANT0) && adv.
  - in1_ready = (state==GRANT1) && adv.
  - A non-granted requester's ready is always 0. Its valid may remain asserted and must hold its data.
- Accepted beat: in_k_valid && in_k_ready. On the next clock:
  - out_valid=1;
  - out_data = the granted input's data;
  - out_src = k;
  - out_last = in_k_last || (count == MAX_BURST-1).
  - Latency from input acceptance to out_valid is exactly 1 cycle.
- No beat accepted and out_ready=1: out_valid clears to 0 on the next clock. out_data, out_last and out_src hold their values.
- Backpressure: while out_ready=0 and out_valid=1, the output register holds and both readys are 0. No beat is ever lost or duplicated.
- Full throughput: with out_ready held at 1, one beat per cycle is accepted within a grant.
- Beat counter (width ceil(log2(MAX_BURST+1))):
  - Increments on each accepted beat.
  - Clears to 0 on grant release.
- Grant release: on the accepted beat where in_k_last=1 or count==MAX_BURST-1:
  - next state = IDLE;
  - pointer = 1-k, so the other requester is preferred next.
- Requests in GRANTk: a valid from the other requester does not preempt the grant.
- MAX_BURST=1: every beat releases the grant. A single requester sees alternate bubbles; two active requesters alternate strictly.
- Idle requester: if the granted requester deasserts valid mid-burst, the grant is held and the block waits. There is no timeout.

Decomposition:
- Shared package mux_arb_pkg holds:
  - state typedef/localparams: IDLE=2'd0, GRANT0=2'd1, GRANT1=2'd2;
  - the SRC_IN0/SRC_IN1 constants.
- One natural sub-module: the existing parameterised 2:1 mux, instantiated with WIDTH and select=(state==GRANT1), feeding the output register.
- FSM, counter and pointer stay in the top.

Test Plan:
1. Single requester: in0 sends 3 beats 8'hAA,8'hBB,8'hCC with last on 8'hCC, out_ready=1 → out_valid beats AA,BB,CC on consecutive cycles, out_src=0, out_last only on CC; in1_ready never asserted.
2. Both requesting from reset: in0 sends bursts of 8'h10,8'h11(last); in1 sends 8'h20,8'h21(last) → output order 10,11,<1 bubble>,20,21; out_src 0,0,1,1.
3. Burst cap: MAX_BURST=4, in0 streams 8'h01..8'h06 with no last while in1 is valid with 8'h55 → beats 01..04 (out_last on 04), then 55 from in1 (in1_last=1), then 05,06 from in0.
4. Backpressure: mid-burst, hold out_ready=0 for 5 cycles with out_data=8'h3C pending → out_data stays 3C with out_valid=1, in0_ready=0 throughout; on release 3C is consumed once and the next beat follows.
5. Async reset mid-burst: pulse rst_n low between clock edges during an in1 burst → out_valid, readys and out_src drop to 0 immediately. After release, with both valid, in0 is granted first.
6. MAX_BURST=1 with both continuously valid (in0=8'hF0, in1=8'h0F) → output alternates F0,0F,F0,0F, one bubble between beats, out_last=1 on every beat.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared state encoding and source identifiers for the two-requester
// round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic SRC_IN0 = 1'b0;
    localparam logic SRC_IN1 = 1'b1;

    // The requester that should be preferred after src finishes its burst.
    function automatic logic other_src(input logic src);
        return (src == SRC_IN0) ? SRC_IN1 : SRC_IN0;
    endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Two valid/ready/last request streams in, one registered stream out.
// The slave modport is the arbiter side; master is the producers/consumer side.
interface mux_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in0_ready;

    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             in1_ready;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_src;
    logic             out_ready;

    modport slave (
        input  in0_valid, in0_data, in0_last,
        output in0_ready,
        input  in1_valid, in1_data, in1_last,
        output in1_ready,
        output out_valid, out_data, out_last, out_src,
        input  out_ready
    );

    modport master (
        output in0_valid, in0_data, in0_last,
        input  in0_ready,
        output in1_valid, in1_data, in1_last,
        input  in1_ready,
        input  out_valid, out_data, out_last, out_src,
        output out_ready
    );

endinterface

// File: rtl/mux_arbiter_mux2.sv
// Parameterised 2:1 datapath mux shared by the two requesters.
module mux_arbiter_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter with burst locking that shares one 2:1 mux between two
// streaming requesters and drives a one-beat-deep registered output.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_arbiter_if.slave bus
);

    localparam int CW = $clog2(MAX_BURST + 1);

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic             r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_src;

    logic             w_sel;
    logic             w_granted;
    logic             w_adv;
    logic             w_valid;
    logic             w_last;
    logic             w_acc;
    logic             w_close;
    logic [WIDTH-1:0] w_mux_data;

    assign w_sel     = (r_state == GRANT1);
    assign w_granted = (r_state == GRANT0) || (r_state == GRANT1);
    assign w_adv     = !r_out_valid || bus.out_ready;

    assign bus.in0_ready = (r_state == GRANT0) && w_adv;
    assign bus.in1_ready = (r_state == GRANT1) && w_adv;

    assign w_valid = w_sel ? bus.in1_valid : bus.in0_valid;
    assign w_last  = w_sel ? bus.in1_last  : bus.in0_last;
    assign w_acc   = w_granted && w_valid && w_adv;
    // A burst closes on an explicit last or on the MAX_BURST-th accepted beat.
    assign w_close = w_last || (r_count == CW'(MAX_BURST - 1));

    mux_arbiter_mux2 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .i_sel (w_sel),
        .i_d0  (bus.in0_data),
        .i_d1  (bus.in1_data),
        .o_y   (w_mux_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_ptr       <= SRC_IN0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= SRC_IN0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in0_valid && (!bus.in1_valid || r_ptr == SRC_IN0)) begin
                        r_state <= GRANT0;
                    end else if (bus.in1_valid) begin
                        r_state <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (w_acc) begin
                        if (w_close) begin
                            r_state <= IDLE;
                            r_count <= '0;
                            r_ptr   <= other_src(w_sel);
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Data/last/src only move on an accepted beat; a drain just drops valid.
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_last  <= w_close;
                r_out_src   <= w_sel;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: directed bursts on a MAX_BURST=4 instance
// and a MAX_BURST=1 instance, with a negedge monitor popping expected beats.
module tb_mux_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       src;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;
    logic in1_rdy_seen = 1'b0;

    beat_t q_a[$];
    beat_t q_b[$];
    int    stamp_a[$];
    int    stamp_b[$];

    always #5 clk = ~clk;

    mux_arbiter_if #(.WIDTH(8)) ifa ();
    mux_arbiter_if #(.WIDTH(8)) ifb ();

    mux_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    mux_arbiter #(.WIDTH(8), .MAX_BURST(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d, input logic l, input logic s);
        beat_t b;
        b.data = d;
        b.last = l;
        b.src  = s;
        return b;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops and compares whenever a DUT hands over an output beat.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (ifa.in1_ready === 1'b1) in1_rdy_seen = 1'b1;
            if (ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
                if (q_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_extra_beat: got data %0h src %0h, expected no beat", ifa.out_data, ifa.out_src);
                end else begin
                    e = q_a.pop_front();
                    check("a_data", 32'(ifa.out_data), 32'(e.data));
                    check("a_last", 32'(ifa.out_last), 32'(e.last));
                    check("a_src",  32'(ifa.out_src),  32'(e.src));
                    stamp_a.push_back(cyc);
                end
            end
            if (ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
                if (q_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_extra_beat: got data %0h src %0h, expected no beat", ifb.out_data, ifb.out_src);
                end else begin
                    e = q_b.pop_front();
                    check("b_data", 32'(ifb.out_data), 32'(e.data));
                    check("b_last", 32'(ifb.out_last), 32'(e.last));
                    check("b_src",  32'(ifb.out_src),  32'(e.src));
                    stamp_b.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic idle_inputs();
        ifa.in0_valid = 1'b0; ifa.in0_data = '0; ifa.in0_last = 1'b0;
        ifa.in1_valid = 1'b0; ifa.in1_data = '0; ifa.in1_last = 1'b0;
        ifb.in0_valid = 1'b0; ifb.in0_data = '0; ifb.in0_last = 1'b0;
        ifb.in1_valid = 1'b0; ifb.in1_data = '0; ifb.in1_last = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Present one beat on in0 of the MAX_BURST=4 instance until it is taken.
    task automatic send0(input logic [7:0] d, input logic l);
        int   n = 0;
        logic acc = 1'b0;
        ifa.in0_valid = 1'b1;
        ifa.in0_data  = d;
        ifa.in0_last  = l;
        do begin
            @(negedge clk);
            acc = ifa.in0_valid && ifa.in0_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 60);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send0_timeout: beat %0h accepted=0, expected accepted=1", d);
        end
        ifa.in0_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input logic l);
        int   n = 0;
        logic acc = 1'b0;
        ifa.in1_valid = 1'b1;
        ifa.in1_data  = d;
        ifa.in1_last  = l;
        do begin
            @(negedge clk);
            acc = ifa.in1_valid && ifa.in1_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 60);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send1_timeout: beat %0h accepted=0, expected accepted=1", d);
        end
        ifa.in1_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n = 0;
        while (q_a.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("a_drained", 32'(q_a.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drain_b();
        int n = 0;
        while (q_b.size() != 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b_drained", 32'(q_b.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int   n;
        logic seen;
        int   hs;

        idle_inputs();
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_out_data",  32'(ifa.out_data),  32'd0);
        check("rst_out_last",  32'(ifa.out_last),  32'd0);
        check("rst_out_src",   32'(ifa.out_src),   32'd0);
        check("rst_in0_ready", 32'(ifa.in0_ready), 32'd0);
        check("rst_in1_ready", 32'(ifa.in1_ready), 32'd0);

        // Single requester, three back-to-back beats.
        do_reset();
        stamp_a.delete();
        in1_rdy_seen = 1'b0;
        q_a.push_back(mk(8'hAA, 1'b0, 1'b0));
        q_a.push_back(mk(8'hBB, 1'b0, 1'b0));
        q_a.push_back(mk(8'hCC, 1'b1, 1'b0));
        send0(8'hAA, 1'b0);
        send0(8'hBB, 1'b0);
        send0(8'hCC, 1'b1);
        drain_a();
        check("t1_in1_ready_seen", 32'(in1_rdy_seen), 32'd0);
        check("t1_nbeats", 32'(stamp_a.size()), 32'd3);
        if (stamp_a.size() == 3) begin
            check("t1_gap01", 32'(stamp_a[1] - stamp_a[0]), 32'd1);
            check("t1_gap12", 32'(stamp_a[2] - stamp_a[1]), 32'd1);
        end

        // Both requesting from reset: in0 first, one bubble, then in1.
        do_reset();
        stamp_a.delete();
        q_a.push_back(mk(8'h10, 1'b0, 1'b0));
        q_a.push_back(mk(8'h11, 1'b1, 1'b0));
        q_a.push_back(mk(8'h20, 1'b0, 1'b1));
        q_a.push_back(mk(8'h21, 1'b1, 1'b1));
        fork
            begin send0(8'h10, 1'b0); send0(8'h11, 1'b1); end
            begin send1(8'h20, 1'b0); send1(8'h21, 1'b1); end
        join
        drain_a();
        check("t2_nbeats", 32'(stamp_a.size()), 32'd4);
        if (stamp_a.size() == 4) begin
            check("t2_gap_in0", 32'(stamp_a[1] - stamp_a[0]), 32'd1);
            check("t2_bubble",  32'(stamp_a[2] - stamp_a[1]), 32'd2);
            check("t2_gap_in1", 32'(stamp_a[3] - stamp_a[2]), 32'd1);
        end

        // Burst cap of 4 forces a handover to the waiting in1.
        do_reset();
        q_a.push_back(mk(8'h01, 1'b0, 1'b0));
        q_a.push_back(mk(8'h02, 1'b0, 1'b0));
        q_a.push_back(mk(8'h03, 1'b0, 1'b0));
        q_a.push_back(mk(8'h04, 1'b1, 1'b0));
        q_a.push_back(mk(8'h55, 1'b1, 1'b1));
        q_a.push_back(mk(8'h05, 1'b0, 1'b0));
        q_a.push_back(mk(8'h06, 1'b0, 1'b0));
        fork
            begin
                for (int i = 1; i <= 6; i++) send0(8'(i), 1'b0);
            end
            send1(8'h55, 1'b1);
        join
        drain_a();

        // Backpressure with 3C held on the output for five cycles.
        do_reset();
        q_a.push_back(mk(8'h3B, 1'b0, 1'b0));
        q_a.push_back(mk(8'h3C, 1'b0, 1'b0));
        q_a.push_back(mk(8'h3D, 1'b1, 1'b0));
        fork
            begin send0(8'h3B, 1'b0); send0(8'h3C, 1'b0); send0(8'h3D, 1'b1); end
            begin
                n = 0;
                while (!(ifa.out_valid === 1'b1 && ifa.out_data === 8'h3C) && n < 40) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                seen = (ifa.out_valid === 1'b1 && ifa.out_data === 8'h3C);
                check("t4_seen_3c", 32'(seen), 32'd1);
                ifa.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("t4_hold_valid", 32'(ifa.out_valid), 32'd1);
                    check("t4_hold_data",  32'(ifa.out_data),  32'h3C);
                    check("t4_in0_ready",  32'(ifa.in0_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                ifa.out_ready = 1'b1;
            end
        join
        drain_a();

        // Asynchronous reset in the middle of an in1 burst.
        do_reset();
        ifa.in1_valid = 1'b1;
        ifa.in1_data  = 8'hA0;
        ifa.in1_last  = 1'b0;
        n = 0;
        while (!(ifa.out_valid === 1'b1 && ifa.out_src === 1'b1) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        seen = (ifa.out_valid === 1'b1 && ifa.out_src === 1'b1);
        check("t5_in1_burst_seen", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        ifa.in0_valid = 1'b1;
        ifa.in0_data  = 8'h5A;
        ifa.in0_last  = 1'b1;
        ifa.in1_data  = 8'hA5;
        ifa.in1_last  = 1'b1;
        #1;
        check("t5_out_valid", 32'(ifa.out_valid), 32'd0);
        check("t5_out_src",   32'(ifa.out_src),   32'd0);
        check("t5_out_data",  32'(ifa.out_data),  32'd0);
        check("t5_out_last",  32'(ifa.out_last),  32'd0);
        check("t5_in0_ready", 32'(ifa.in0_ready), 32'd0);
        check("t5_in1_ready", 32'(ifa.in1_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_a.push_back(mk(8'h5A, 1'b1, 1'b0));
        q_a.push_back(mk(8'hA5, 1'b1, 1'b1));
        fork
            send0(8'h5A, 1'b1);
            send1(8'hA5, 1'b1);
        join
        drain_a();

        // MAX_BURST=1 instance: strict alternation with a bubble between beats.
        do_reset();
        stamp_b.delete();
        q_b.push_back(mk(8'hF0, 1'b1, 1'b0));
        q_b.push_back(mk(8'h0F, 1'b1, 1'b1));
        q_b.push_back(mk(8'hF0, 1'b1, 1'b0));
        q_b.push_back(mk(8'h0F, 1'b1, 1'b1));
        ifb.in0_valid = 1'b1; ifb.in0_data = 8'hF0; ifb.in0_last = 1'b0;
        ifb.in1_valid = 1'b1; ifb.in1_data = 8'h0F; ifb.in1_last = 1'b0;
        hs = 0;
        n  = 0;
        while (hs < 4 && n < 40) begin
            @(negedge clk);
            if (ifb.in0_valid && ifb.in0_ready) hs++;
            if (ifb.in1_valid && ifb.in1_ready) hs++;
            @(posedge clk);
            #1;
            n++;
        end
        ifb.in0_valid = 1'b0;
        ifb.in1_valid = 1'b0;
        check("t6_handshakes", 32'(hs), 32'd4);
        drain_b();
        check("t6_nbeats", 32'(stamp_b.size()), 32'd4);
        if (stamp_b.size() == 4) begin
            check("t6_gap01", 32'(stamp_b[1] - stamp_b[0]), 32'd2);
            check("t6_gap12", 32'(stamp_b[2] - stamp_b[1]), 32'd2);
            check("t6_gap23", 32'(stamp_b[3] - stamp_b[2]), 32'd2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
